// File: rtl/temporizador_bcd_regressivo_pkg.sv
// Shared definitions for the BCD countdown timer (MM:SS).
// Holds the FSM state encoding, BCD constants and the per-digit load clamp.
package temporizador_bcd_regressivo_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        PAUSADO  = 2'd2
    } estado_t;

    localparam logic [3:0]  BCD_MAX_UNID = 4'd9;
    localparam logic [15:0] ZERO_MMSS    = 16'h0000;

    // Saturates one BCD digit at its maximum legal value.
    function automatic logic [3:0] limita_digito(input logic [3:0] dig,
                                                 input logic [3:0] dig_max);
        return (dig > dig_max) ? dig_max : dig;
    endfunction

endpackage

// File: rtl/temporizador_bcd_regressivo_decrementador_bcd.sv
// One BCD digit of a decrement/borrow chain (combinational).
// Ports:
//   dig_i        current digit value
//   dig_max_i    value the digit wraps to when borrowing past 0
//   borrow_in_i  1 = subtract one from this digit
//   dig_out_o    resulting digit
//   borrow_out_o 1 = this digit wrapped and the next digit must subtract one
module decrementador_bcd (
    input  logic [3:0] dig_i,
    input  logic [3:0] dig_max_i,
    input  logic       borrow_in_i,
    output logic [3:0] dig_out_o,
    output logic       borrow_out_o
);

    always_comb begin
        dig_out_o    = dig_i;
        borrow_out_o = 1'b0;
        if (borrow_in_i) begin
            if (dig_i == 4'd0) begin
                dig_out_o    = dig_max_i;
                borrow_out_o = 1'b1;
            end else begin
                dig_out_o = dig_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/temporizador_bcd_regressivo.sv
// Two-field BCD countdown timer (MM:SS) used for snooze/countdown.
// Loads a clamped BCD value, decrements once per tick_1hz while counting and
// pulses fim for one cycle when the count reaches 00:00.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   tick_1hz             one-cycle pulse per second
//   carregar             load carga_min/carga_seg (clamped per digit)
//   carga_min, carga_seg BCD load value, [7:4] tens, [3:0] units
//   iniciar, pausar      start/resume and pause requests
//   min, seg             current registered BCD count
//   ativo                1 while counting
//   fim                  one-cycle pulse at terminal count
//   estado_dbg           current FSM state, for observation
// Handshake: all control inputs are single-cycle level requests sampled on
// the rising edge; there is no back-pressure. Per-cycle priority is
// rst > carregar > pausar > iniciar > tick_1hz; a request that has no effect
// in the current state does not block lower-priority ones.
module temporizador_bcd_regressivo
    import temporizador_bcd_regressivo_pkg::*;
#(
    parameter logic [3:0] MIN_DEZ_MAX = 4'd9,
    parameter logic [3:0] SEG_DEZ_MAX = 4'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       carregar,
    input  logic [7:0] carga_min,
    input  logic [7:0] carga_seg,
    input  logic       iniciar,
    input  logic       pausar,
    output logic [7:0] min,
    output logic [7:0] seg,
    output logic       ativo,
    output logic       fim,
    output logic [1:0] estado_dbg
);

    estado_t     estado_q, estado_d;
    logic [15:0] cont_q, cont_d;     // {min, seg}
    logic        ativo_q, ativo_d;
    logic        fim_q, fim_d;

    // Borrow chain: seconds units -> seconds tens -> minutes units -> tens.
    logic [15:0] cont_dec;
    logic [3:0]  borrow;

    decrementador_bcd u_seg_unid (
        .dig_i(cont_q[3:0]),   .dig_max_i(BCD_MAX_UNID), .borrow_in_i(1'b1),
        .dig_out_o(cont_dec[3:0]),   .borrow_out_o(borrow[0])
    );
    decrementador_bcd u_seg_dez (
        .dig_i(cont_q[7:4]),   .dig_max_i(SEG_DEZ_MAX),  .borrow_in_i(borrow[0]),
        .dig_out_o(cont_dec[7:4]),   .borrow_out_o(borrow[1])
    );
    decrementador_bcd u_min_unid (
        .dig_i(cont_q[11:8]),  .dig_max_i(BCD_MAX_UNID), .borrow_in_i(borrow[1]),
        .dig_out_o(cont_dec[11:8]),  .borrow_out_o(borrow[2])
    );
    decrementador_bcd u_min_dez (
        .dig_i(cont_q[15:12]), .dig_max_i(MIN_DEZ_MAX),  .borrow_in_i(borrow[2]),
        .dig_out_o(cont_dec[15:12]), .borrow_out_o(borrow[3])
    );

    logic [15:0] carga_limitada;
    always_comb begin
        carga_limitada = {limita_digito(carga_min[7:4], MIN_DEZ_MAX),
                          limita_digito(carga_min[3:0], BCD_MAX_UNID),
                          limita_digito(carga_seg[7:4], SEG_DEZ_MAX),
                          limita_digito(carga_seg[3:0], BCD_MAX_UNID)};
    end

    // State/count register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= OCIOSO;
            cont_q   <= ZERO_MMSS;
            ativo_q  <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            ativo_q  <= ativo_d;
            fim_q    <= fim_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        cont_d   = cont_q;
        fim_d    = 1'b0;
        if (carregar) begin
            estado_d = OCIOSO;
            cont_d   = carga_limitada;
        end else if (pausar && estado_q == CONTANDO) begin
            estado_d = PAUSADO;
        end else if (iniciar && ((estado_q == OCIOSO && cont_q != ZERO_MMSS) ||
                                 estado_q == PAUSADO)) begin
            estado_d = CONTANDO;
        end else if (tick_1hz && estado_q == CONTANDO && cont_q != ZERO_MMSS) begin
            cont_d = cont_dec;
            if (cont_dec == ZERO_MMSS) begin
                estado_d = OCIOSO;
                fim_d    = 1'b1;
            end
        end
        ativo_d = (estado_d == CONTANDO);
    end

    // Outputs
    always_comb begin
        min        = cont_q[15:8];
        seg        = cont_q[7:0];
        ativo      = ativo_q;
        fim        = fim_q;
        estado_dbg = estado_q;
    end

endmodule

// File: tb/tb_temporizador_bcd_regressivo.sv
module tb_temporizador_bcd_regressivo;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, carregar, iniciar, pausar;
    logic [7:0] carga_min, carga_seg;
    logic [7:0] min, seg;
    logic       ativo, fim;
    logic [1:0] estado_dbg;

    int n_chk  = 0;
    int n_pass = 0;

    localparam logic [1:0] S_OCIOSO = 2'd0, S_CONTANDO = 2'd1, S_PAUSADO = 2'd2;

    temporizador_bcd_regressivo dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .carregar(carregar),
        .carga_min(carga_min), .carga_seg(carga_seg), .iniciar(iniciar),
        .pausar(pausar), .min(min), .seg(seg), .ativo(ativo), .fim(fim),
        .estado_dbg(estado_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // checking
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_all(input string tag, input logic [15:0] mmss,
                             input logic a, input logic f, input logic [1:0] st);
        check({tag, " mmss"},  {min, seg}, mmss);
        check({tag, " ativo"}, {15'd0, ativo}, {15'd0, a});
        check({tag, " fim"},   {15'd0, fim}, {15'd0, f});
        check({tag, " estado"}, {14'd0, estado_dbg}, {14'd0, st});
    endtask

    // drivers: inputs held for one rising edge, then outputs settle (#1)
    task automatic cyc();
        @(posedge clk);
        #1;
        tick_1hz = 1'b0; carregar = 1'b0; iniciar = 1'b0; pausar = 1'b0; rst = 1'b0;
    endtask

    task automatic load(input logic [7:0] m, input logic [7:0] s);
        carregar = 1'b1; carga_min = m; carga_seg = s; cyc();
    endtask

    task automatic start();
        iniciar = 1'b1; cyc();
    endtask

    task automatic tick();
        tick_1hz = 1'b1; cyc();
    endtask

    initial begin
        tick_1hz = 0; carregar = 0; iniciar = 0; pausar = 0;
        carga_min = 8'h00; carga_seg = 8'h00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; cyc();
        check_all("reset", 16'h0000, 0, 0, S_OCIOSO);

        // 1: 01:00 -> 00:59
        load(8'h01, 8'h00);
        check_all("t1 load", 16'h0100, 0, 0, S_OCIOSO);
        start();
        check_all("t1 start", 16'h0100, 1, 0, S_CONTANDO);
        tick();
        check_all("t1 tick", 16'h0059, 1, 0, S_CONTANDO);

        // 2: terminal count
        load(8'h00, 8'h01);
        start();
        tick();
        check_all("t2 end", 16'h0000, 0, 1, S_OCIOSO);
        cyc();
        check_all("t2 fim drop", 16'h0000, 0, 0, S_OCIOSO);
        tick();
        check_all("t2 tick1", 16'h0000, 0, 0, S_OCIOSO);
        tick();
        check_all("t2 tick2", 16'h0000, 0, 0, S_OCIOSO);

        // 3: minute borrow
        load(8'h10, 8'h00);
        start();
        tick();
        check_all("t3 09:59", 16'h0959, 1, 0, S_CONTANDO);
        for (int i = 0; i < 60; i++) begin
            tick();
            cyc();
        end
        check_all("t3 08:59", 16'h0859, 1, 0, S_CONTANDO);

        // 4: clamp, zero start ignored
        load(8'h7A, 8'h6F);
        check_all("t4 clamp", 16'h7959, 0, 0, S_OCIOSO);
        load(8'hF3, 8'h8C);
        check_all("t4 clamp2", 16'h9359, 0, 0, S_OCIOSO);
        load(8'h00, 8'h00);
        start();
        check_all("t4 zero start", 16'h0000, 0, 0, S_OCIOSO);
        cyc();
        check_all("t4 zero idle", 16'h0000, 0, 0, S_OCIOSO);

        // 5: pause
        load(8'h05, 8'h31);
        start();
        tick();
        check_all("t5 05:30", 16'h0530, 1, 0, S_CONTANDO);
        pausar = 1'b1; tick_1hz = 1'b1; cyc();
        check_all("t5 pause+tick", 16'h0530, 0, 0, S_PAUSADO);
        for (int i = 0; i < 3; i++) tick();
        check_all("t5 paused ticks", 16'h0530, 0, 0, S_PAUSADO);
        iniciar = 1'b1; tick_1hz = 1'b1; cyc();
        check_all("t5 resume+tick", 16'h0530, 1, 0, S_CONTANDO);
        tick();
        check_all("t5 05:29", 16'h0529, 1, 0, S_CONTANDO);
        iniciar = 1'b1; tick_1hz = 1'b1; cyc();
        check_all("t5 start while running", 16'h0528, 1, 0, S_CONTANDO);

        // 6: reset and load mid-count
        load(8'h02, 8'h00);
        start();
        rst = 1'b1; tick_1hz = 1'b1; cyc();
        check_all("t6 rst", 16'h0000, 0, 0, S_OCIOSO);
        load(8'h03, 8'h00);
        start();
        tick();
        check_all("t6 02:59", 16'h0259, 1, 0, S_CONTANDO);
        carregar = 1'b1; carga_min = 8'h04; carga_seg = 8'h15; tick_1hz = 1'b1; cyc();
        check_all("t6 reload", 16'h0415, 0, 0, S_OCIOSO);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
